pipe_mul_rr_arbiter: RTL and testbench
======================================

# pipe_mul_rr_arbiter

Round-robin arbiter that shares one always-on pipelined unsigned-integer multiplier between `NREQ` requesters. It owns the multiplier instance, issues at most one operation per cycle, and tracks the requester ID alongside the operands through the pipeline. Each result is returned tagged to its originating requester. It sits between the PE-level datapath lanes and a single multiplier resource, where multiplier area must be amortised across lanes.

## Interface
- `N`, 32: operand and result width in bits.
- `NREQ`, 4: number of requesters; 2..16.
- `TW`, 2: tag width, equal to ceil(log2(`NREQ`)); set by the instantiating module.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in `NREQ`: bit i asserts that requester i has an operation pending.
- `req_in1` in `NREQ`*`N`: packed first operands; requester i uses bits [i*N +: N].
- `req_in2` in `NREQ`*`N`: packed second operands, same packing as `req_in1`.
- `req_ready` out `NREQ`: one-hot grant; bit i high means requester i's operands are consumed this cycle.
- `res_valid` out `NREQ`: one-hot; bit i high means `res_data` belongs to requester i.
- `res_tag` out `TW`: binary requester ID of the current result.
- `res_data` out `N`: product, computed modulo 2^`N`.
- `inflight` out `TW`+1: number of accepted operations whose results have not yet been presented.

## Operation
- Arbitration is combinational within a cycle.
  - `req_ready` is one-hot or zero.
  - The granted requester is the first i with `req_valid[i]` high, searching from `last+1` upward with wrap-around modulo `NREQ`.
- `last` pointer:
  - Updates to the granted index on every cycle with a grant.
  - Holds its value when no requester is valid.
  - Reset value `NREQ`-1, so requester 0 wins first after reset.
- A request is accepted when `req_valid[i]` and `req_ready[i]` are both high.
  - The requester must hold its operands stable while valid and not granted.
  - Deasserting `req_valid` before grant is permitted; the request is simply withdrawn.
- On acceptance:
  - The selected operands are registered into the multiplier input stage.
  - The grant index is registered into a tag stage together with a valid bit.
- Result path:
  - Product = (in1 * in2) mod 2^`N`; overflow is silently truncated.
  - There is no result back-pressure. Consumers must accept every cycle that `res_valid` is nonzero.
- Operands, tag and valid registers are all reset. Outputs after reset:
  - `res_data` = 0
  - `res_valid` = 0
  - `res_tag` = 0
  - `inflight` = 0
  - `req_ready` follows `req_valid` combinationally.
- When no grant occurs:
  - The valid bit clears and `res_valid` returns to 0.
  - `res_data` holds its last value.
- Reset mid-operation discards all in-flight operations. No result is produced for them, and `inflight` returns to 0 on the next edge.

## Timing
- Throughput: one operation per cycle, sustained.
- Latency without output register: accepted in cycle t, so `res_valid`, `res_tag` and `res_data` are valid during cycle t+1.
- `inflight`:
  - Incremented on acceptance and decremented when a result is presented.
  - Simultaneous accept and present leaves it unchanged.
  - Maximum value is the pipeline depth: 1, or 2 with the output register.
- Grant fairness: with all `NREQ` requesters continuously valid, each is granted exactly once every `NREQ` cycles.
- A single requester continuously valid is granted every cycle.

## Configuration
- `MULARB_OUTREG_EN`, when defined:
  - Adds a reset register stage after the product on `res_data`, `res_valid` and `res_tag`.
  - Latency becomes 2 (accept in t, result in t+2); throughput is unchanged.
  - The maximum value of `inflight` becomes 2.
- When `MULARB_OUTREG_EN` is undefined: latency is 1 and the product path is combinational from the operand registers.

## Test plan
- Reset, then all `req_valid`=0 -> `res_valid`=0, `res_data`=0, `inflight`=0, and `req_ready`=0 for 10 cycles.
- Requester 2 alone, operands 7 and 6, valid for one cycle -> `req_ready`=4'b0100 that cycle; one cycle later (two cycles with OUTREG) `res_valid`=4'b0100, `res_tag`=2, `res_data`=42.
- All 4 requesters valid for 8 cycles, requester i using operands (i+1, 10) -> grant order 0,1,2,3,0,1,2,3; results 10,20,30,40 repeating, each tagged correctly.
- Overflow with N=32: operands 0xFFFF_FFFF and 2 -> `res_data`=0xFFFF_FFFE.
- Requesters 1 and 3 valid and `last`=1 -> requester 3 granted; next cycle requester 1 granted; the pointer wraps past requester 0, which is idle.
- Continuous requests and `rst` asserted for one cycle mid-stream -> no result produced for the operation accepted in the cycle before reset; `inflight`=0 after the edge; requester 0 is granted first after reset.

Source files
------------

// File: rtl/pipe_mul_rr_arbiter.sv
// pipe_mul_rr_arbiter: round-robin share of one pipelined multiplier.
// Grants one requester per cycle, tags results with the requester ID.
//
// Parameters:
//   N    operand/result width
//   NREQ number of requesters (2..16)
//   TW   tag width, ceil(log2(NREQ))
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid[NREQ]      per-requester pending operation
//   req_in1/req_in2      packed operands, requester i at [i*N +: N]
//   req_ready[NREQ]      one-hot grant (operands consumed this cycle)
//   res_valid[NREQ]      one-hot owner of res_data
//   res_tag[TW]          binary owner ID of the result
//   res_data[N]          product modulo 2^N
//   inflight[TW+1]       accepted operations not yet presented
// Configuration:
//   MULARB_OUTREG_EN     adds an output register stage (latency 2)

module pipe_mul_rr_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int TW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_in1,
  input  logic [NREQ*N-1:0] req_in2,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   res_valid,
  output logic [TW-1:0]     res_tag,
  output logic [N-1:0]      res_data,
  output logic [TW:0]       inflight
);

  logic [TW-1:0]   r_last;
  logic [NREQ-1:0] w_gnt;
  logic [TW-1:0]   w_gidx;
  logic [TW-1:0]   w_idx;
  logic            w_acc;
  logic [N-1:0]    w_a;
  logic [N-1:0]    w_b;

  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [TW-1:0]   r_tag;
  logic            r_vld;
  logic [N-1:0]    w_prod;

  logic            w_pvld;
  logic [TW-1:0]   w_ptag;
  logic [N-1:0]    w_pdata;
  logic [NREQ-1:0] w_onehot;
  logic [TW:0]     r_cnt;

  // Search from last+1 upward with wrap; first valid wins.
  // Nothing is granted while reset is held.
  always_comb begin
    w_gnt  = '0;
    w_gidx = '0;
    w_idx  = '0;
    w_acc  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = TW'((int'(r_last) + k) % NREQ);
      if (!w_acc && req_valid[w_idx]) begin
        w_acc  = 1'b1;
        w_gidx = w_idx;
      end
    end
    if (rst) begin
      w_acc = 1'b0;
    end
    if (w_acc) begin
      w_gnt[w_gidx] = 1'b1;
    end
  end

  assign req_ready = w_gnt;

  assign w_a = req_in1[w_gidx*N +: N];
  assign w_b = req_in2[w_gidx*N +: N];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= TW'(NREQ-1);
    end else if (w_acc) begin
      r_last <= w_gidx;
    end
  end

  // Operands hold when idle so res_data keeps its last product.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_tag <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= w_acc;
      if (w_acc) begin
        r_a   <= w_a;
        r_b   <= w_b;
        r_tag <= w_gidx;
      end
    end
  end

  assign w_prod = r_a * r_b;

`ifdef MULARB_OUTREG_EN
  logic          r_ovld;
  logic [TW-1:0] r_otag;
  logic [N-1:0]  r_odata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovld  <= 1'b0;
      r_otag  <= '0;
      r_odata <= '0;
    end else begin
      r_ovld <= r_vld;
      if (r_vld) begin
        r_otag  <= r_tag;
        r_odata <= w_prod;
      end
    end
  end

  assign w_pvld  = r_ovld;
  assign w_ptag  = r_otag;
  assign w_pdata = r_odata;
`else
  assign w_pvld  = r_vld;
  assign w_ptag  = r_tag;
  assign w_pdata = w_prod;
`endif

  // A result in the reset cycle belongs to a discarded operation.
  always_comb begin
    w_onehot = '0;
    if (w_pvld && !rst) begin
      w_onehot[w_ptag] = 1'b1;
    end
  end

  assign res_valid = w_onehot;
  assign res_tag   = w_ptag;
  assign res_data  = w_pdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      unique case ({w_acc, w_pvld})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign inflight = r_cnt;

endmodule

// File: tb/tb_pipe_mul_rr_arbiter.sv
// tb_pipe_mul_rr_arbiter: directed bench with a cycle model.
// Checks every cycle against the model plus literal expectations.

module tb_pipe_mul_rr_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int TW   = 2;
`ifdef MULARB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_in1;
  logic [NREQ*N-1:0] req_in2;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   res_valid;
  logic [TW-1:0]     res_tag;
  logic [N-1:0]      res_data;
  logic [TW:0]       inflight;

  pipe_mul_rr_arbiter #(.N(N), .NREQ(NREQ), .TW(TW)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_in1(req_in1),
    .req_in2(req_in2),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_tag(res_tag),
    .res_data(res_data),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: pointer, a LAT-deep result pipe, last presented data.
  int           mlast = NREQ-1;
  bit           pv[1:2];
  int           ptag[1:2];
  logic [N-1:0] pdata[1:2];
  logic [N-1:0] exp_data = '0;
  bit           chk_en = 1'b0;

  int           gq[$];
  int           tq[$];
  logic [N-1:0] dq[$];

  function automatic int grant_of(logic [NREQ-1:0] v, int last);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (last + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] mulmod(logic [N-1:0] a,
                                          logic [N-1:0] b);
    logic [2*N-1:0] f;
    f = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    return f[N-1:0];
  endfunction

  function automatic int idx_of(logic [NREQ-1:0] oh);
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int g;
    if (rst) begin
      mlast    = NREQ-1;
      pv[1]    = 1'b0;
      pv[2]    = 1'b0;
      exp_data = '0;
      chk_en   = 1'b1;
    end else begin
      g = grant_of(req_valid, mlast);
      pv[2]    = pv[1];
      ptag[2]  = ptag[1];
      pdata[2] = pdata[1];
      pv[1]    = (g >= 0);
      if (g >= 0) begin
        ptag[1]  = g;
        pdata[1] = mulmod(req_in1[g*N +: N], req_in2[g*N +: N]);
        mlast    = g;
      end
      if (LAT == 1) pv[2] = 1'b0;
      if (pv[LAT]) exp_data = pdata[LAT];
    end
  end

  always @(negedge clk) begin : compare
    int g;
    logic [NREQ-1:0] er;
    logic [NREQ-1:0] ev;
    int cnt;
    if (chk_en) begin
      g  = grant_of(req_valid, mlast);
      er = (rst || g < 0) ? '0 : NREQ'(1) << g;
      chk("req_ready", 64'(req_ready), 64'(er));
      ev = (!rst && pv[LAT]) ? NREQ'(1) << ptag[LAT] : '0;
      chk("res_valid", 64'(res_valid), 64'(ev));
      if (ev != '0) chk("res_tag", 64'(res_tag), 64'(ptag[LAT]));
      chk("res_data", 64'(res_data), 64'(exp_data));
      cnt = int'(pv[1]) + int'(pv[2]);
      chk("inflight", 64'(inflight), 64'(cnt));
      if (req_ready != '0) gq.push_back(idx_of(req_ready));
      if (res_valid != '0) begin
        tq.push_back(int'(res_tag));
        dq.push_back(res_data);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clrq();
    gq.delete();
    tq.delete();
    dq.delete();
  endtask

  task automatic set_op(int i, logic [N-1:0] a, logic [N-1:0] b);
    req_in1[i*N +: N] = a;
    req_in2[i*N +: N] = b;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_in1   = '0;
    req_in2   = '0;
    step(2);
    rst = 1'b0;

    // Idle after reset.
    clrq();
    @(negedge clk);
    chk("idle_res_valid", 64'(res_valid), 64'h0);
    chk("idle_res_data", 64'(res_data), 64'h0);
    chk("idle_res_tag", 64'(res_tag), 64'h0);
    chk("idle_inflight", 64'(inflight), 64'h0);
    step(10);
    chk("idle_grants", 64'(gq.size()), 64'd0);
    chk("idle_results", 64'(dq.size()), 64'd0);

    // Single requester 2: 7*6.
    clrq();
    set_op(2, 32'd7, 32'd6);
    req_valid = 4'b0100;
    step(1);
    req_valid = '0;
    step(4);
    chk("single_ngrant", 64'(gq.size()), 64'd1);
    chk("single_grant", 64'(gq[0]), 64'd2);
    chk("single_nres", 64'(dq.size()), 64'd1);
    chk("single_tag", 64'(tq[0]), 64'd2);
    chk("single_data", 64'(dq[0]), 64'd42);

    // All four valid for 8 cycles after a fresh reset.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    clrq();
    for (int i = 0; i < NREQ; i++) set_op(i, N'(i+1), 32'd10);
    req_valid = '1;
    step(8);
    req_valid = '0;
    step(4);
    chk("all_ngrant", 64'(gq.size()), 64'd8);
    chk("all_nres", 64'(dq.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("all_grant", 64'(gq[i]), 64'(i % 4));
      chk("all_tag", 64'(tq[i]), 64'(i % 4));
      chk("all_data", 64'(dq[i]), 64'(10 * (i % 4 + 1)));
    end

    // Overflow truncation.
    clrq();
    set_op(0, 32'hFFFF_FFFF, 32'd2);
    req_valid = 4'b0001;
    step(1);
    req_valid = '0;
    step(4);
    chk("ovf_grant", 64'(gq[0]), 64'd0);
    chk("ovf_data", 64'(dq[0]), 64'hFFFF_FFFE);

    // Pointer at 1, requesters 1 and 3: 3 wins, then 1.
    clrq();
    set_op(1, 32'd3, 32'd5);
    set_op(3, 32'd4, 32'd9);
    req_valid = 4'b0010;
    step(1);
    req_valid = 4'b1010;
    step(1);
    req_valid = 4'b0010;
    step(1);
    req_valid = '0;
    step(4);
    chk("rr_ngrant", 64'(gq.size()), 64'd3);
    chk("rr_g0", 64'(gq[0]), 64'd1);
    chk("rr_g1", 64'(gq[1]), 64'd3);
    chk("rr_g2", 64'(gq[2]), 64'd1);
    chk("rr_d1", 64'(dq[1]), 64'd36);
    chk("rr_d2", 64'(dq[2]), 64'd15);

    // Reset mid-stream.
    clrq();
    for (int i = 0; i < NREQ; i++) set_op(i, N'(i+2), 32'd3);
    req_valid = '1;
    step(3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_res_valid", 64'(res_valid), 64'h0);
    step(1);
    rst = 1'b0;
    clrq();
    @(negedge clk);
    chk("mid_post_inflight", 64'(inflight), 64'h0);
    chk("mid_post_res_valid", 64'(res_valid), 64'h0);
    step(3);
    req_valid = '0;
    step(4);
    chk("mid_ngrant", 64'(gq.size()), 64'd3);
    chk("mid_first_grant", 64'(gq[0]), 64'd0);
    chk("mid_nres", 64'(dq.size()), 64'd3);
    chk("mid_first_data", 64'(dq[0]), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
